// File: rtl/bilinear_sampler.sv
// Pipelined 10.4 fixed-point bilinear sampler against a four-bank image buffer, with an output FIFO.
// Define BILINEAR_SAMPLER_ROUND_EN to round half up; otherwise the result is truncated.
module bilinear_sampler #(
  parameter int         img_width  = 8,
  parameter int         img_height = 8,
  parameter logic [7:0] fill_value = 8'd0,
  parameter int         fifo_depth = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] in_x,
  input  logic [13:0] in_y,
  output logic [9:0]  rx,
  output logic [9:0]  ry,
  input  logic [7:0]  lu,
  input  logic [7:0]  ru,
  input  logic [7:0]  ld,
  input  logic [7:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pixel
);

  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;
  localparam logic [9:0]    X_MAX   = 10'(img_width - 1);
  localparam logic [9:0]    Y_MAX   = 10'(img_height - 1);
  localparam logic [CW:0]   DEPTH_V = (CW + 1)'(fifo_depth);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
`ifdef BILINEAR_SAMPLER_ROUND_EN
  localparam logic [16:0] RND = 17'd128;
`else
  localparam logic [16:0] RND = 17'd0;
`endif

  logic [9:0]    rx_q, rx_d, ry_q, ry_d;
  logic          in_ready_q, in_ready_d;
  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic [3:0]    fx1_q, fx1_d, fy1_q, fy1_d, fx2_q, fx2_d, fy2_q, fy2_d;
  logic [3:0]    fx3_q, fx3_d, fy3_q, fy3_d, fy4_q, fy4_d;
  logic          oob1_q, oob1_d, oob2_q, oob2_d, oob3_q, oob3_d, oob4_q, oob4_d;
  logic [7:0]    lu3_q, lu3_d, ru3_q, ru3_d, ld3_q, ld3_d, rd3_q, rd3_d;
  logic [11:0]   hu4_q, hu4_d, hd4_q, hd4_d;
  logic [7:0]    mem_q [fifo_depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nx_s;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    inflight_q, inflight_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    head_q, head_d;
  logic          accept_s, pop_s, push_s;
  logic [4:0]    wfx_s, wfy_s;
  logic [16:0]   s_s;
  logic [7:0]    push_pix_s;

  // Next-state logic for the coordinate stage, blend pipeline and output FIFO.
  always_comb begin
    accept_s = in_valid && in_ready_q;
    pop_s    = out_valid_q && out_ready;
    push_s   = v4_q;

    if (accept_s) begin
      rx_d = in_x[13:4];
      ry_d = in_y[13:4];
    end else begin
      rx_d = rx_q;
      ry_d = ry_q;
    end
    v1_d   = accept_s;
    // The last column/row blends only with itself, so the missing neighbour is never used.
    fx1_d  = (in_x[13:4] == X_MAX) ? 4'd0 : in_x[3:0];
    fy1_d  = (in_y[13:4] == Y_MAX) ? 4'd0 : in_y[3:0];
    oob1_d = (in_x[13:4] > X_MAX) || (in_y[13:4] > Y_MAX);

    v2_d = v1_q;  fx2_d = fx1_q;  fy2_d = fy1_q;  oob2_d = oob1_q;
    v3_d = v2_q;  fx3_d = fx2_q;  fy3_d = fy2_q;  oob3_d = oob2_q;
    lu3_d = lu;   ru3_d = ru;     ld3_d = ld;     rd3_d = rd;

    wfx_s  = 5'd16 - {1'b0, fx3_q};
    hu4_d  = ({4'd0, lu3_q} * {7'd0, wfx_s}) + ({4'd0, ru3_q} * {8'd0, fx3_q});
    hd4_d  = ({4'd0, ld3_q} * {7'd0, wfx_s}) + ({4'd0, rd3_q} * {8'd0, fx3_q});
    v4_d   = v3_q;
    fy4_d  = fy3_q;
    oob4_d = oob3_q;

    wfy_s      = 5'd16 - {1'b0, fy4_q};
    s_s        = ({5'd0, hu4_q} * {12'd0, wfy_s}) + ({5'd0, hd4_q} * {13'd0, fy4_q}) + RND;
    push_pix_s = oob4_q ? fill_value : 8'(s_s >> 8);

    count_d    = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    inflight_d = inflight_q + {2'b00, accept_s} - {2'b00, push_s};
    wr_ptr_d   = wr_ptr_q + {{(AW-1){1'b0}}, push_s};
    rd_nx_s    = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    rd_ptr_d   = pop_s ? rd_nx_s : rd_ptr_q;
    // Admission counts every accepted request still in the pipeline, so a push always finds room.
    in_ready_d  = ({1'b0, count_d} + {{(CW-2){1'b0}}, inflight_d}) < DEPTH_V;
    out_valid_d = (count_d != {CW{1'b0}});

    if (count_q == {CW{1'b0}}) begin
      head_d = push_s ? push_pix_s : head_q;
    end else if (pop_s) begin
      if (count_q == ONE_C) begin
        head_d = push_s ? push_pix_s : head_q;
      end else begin
        head_d = mem_q[rd_nx_s];
      end
    end else begin
      head_d = head_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= 10'd0;  ry_q <= 10'd0;  in_ready_q <= 1'b1;
      v1_q <= 1'b0;   v2_q <= 1'b0;   v3_q <= 1'b0;   v4_q <= 1'b0;
      fx1_q <= 4'd0;  fy1_q <= 4'd0;  fx2_q <= 4'd0;  fy2_q <= 4'd0;
      fx3_q <= 4'd0;  fy3_q <= 4'd0;  fy4_q <= 4'd0;
      oob1_q <= 1'b0; oob2_q <= 1'b0; oob3_q <= 1'b0; oob4_q <= 1'b0;
      lu3_q <= 8'd0;  ru3_q <= 8'd0;  ld3_q <= 8'd0;  rd3_q <= 8'd0;
      hu4_q <= 12'd0; hd4_q <= 12'd0;
      wr_ptr_q <= {AW{1'b0}}; rd_ptr_q <= {AW{1'b0}};
      count_q <= {CW{1'b0}};  inflight_q <= 3'd0;
      out_valid_q <= 1'b0;    head_q <= 8'd0;
    end else begin
      rx_q <= rx_d;   ry_q <= ry_d;   in_ready_q <= in_ready_d;
      v1_q <= v1_d;   v2_q <= v2_d;   v3_q <= v3_d;   v4_q <= v4_d;
      fx1_q <= fx1_d; fy1_q <= fy1_d; fx2_q <= fx2_d; fy2_q <= fy2_d;
      fx3_q <= fx3_d; fy3_q <= fy3_d; fy4_q <= fy4_d;
      oob1_q <= oob1_d; oob2_q <= oob2_d; oob3_q <= oob3_d; oob4_q <= oob4_d;
      lu3_q <= lu3_d; ru3_q <= ru3_d; ld3_q <= ld3_d; rd3_q <= rd3_d;
      hu4_q <= hu4_d; hd4_q <= hd4_d;
      wr_ptr_q <= wr_ptr_d;   rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;     inflight_q <= inflight_d;
      out_valid_q <= out_valid_d; head_q <= head_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_pix_s;
    end
  end

  assign rx        = rx_q;
  assign ry        = ry_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pixel = head_q;

endmodule

// File: tb/tb_bilinear_sampler.sv
// Self-checking bench for bilinear_sampler: directed table, backpressure, reset and random traffic
// against an 8x8 image buffer model pixel(x,y)=16*y+x.
module tb_bilinear_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [13:0] in_x, in_y;
  logic [9:0]  rx, ry;
  logic [7:0]  lu, ru, ld, rd, out_pixel;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int exp_q[$];
  logic       hold_v = 1'b0;
  logic [7:0] hold_pix = 8'd0;

`ifdef BILINEAR_SAMPLER_ROUND_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif
  localparam int RB = (RND != 0) ? 1 : 0;

  typedef struct {
    logic [13:0] x;
    logic [13:0] y;
    int          erx;
    int          ery;
    int          epix;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  bilinear_sampler #(
    .img_width(8), .img_height(8), .fill_value(8'd0), .fifo_depth(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .rx(rx), .ry(ry),
    .lu(lu), .ru(ru), .ld(ld), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel)
  );

  // Image contents; addresses past the image return a marker value that must never reach the output.
  function automatic int pix(int x, int y);
    if (x < 8 && y < 8) return 16 * y + x;
    return 238;
  endfunction

  function automatic int ref_pixel(int cx, int cy);
    int x, y, fx, fy, top, bot;
    x = cx / 16;  y = cy / 16;  fx = cx % 16;  fy = cy % 16;
    if (x > 7 || y > 7) return 0;
    if (x == 7) fx = 0;
    if (y == 7) fy = 0;
    top = pix(x, y) * (16 - fx) + pix(x + 1, y) * fx;
    bot = pix(x, y + 1) * (16 - fx) + pix(x + 1, y + 1) * fx;
    return (top * (16 - fy) + bot * fy + RND) / 256;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Image buffer model: neighbours appear one edge after rx/ry, sampled by the DUT on the next edge.
  always @(posedge clk) begin
    lu <= 8'(pix(int'(rx), int'(ry)));
    ru <= 8'(pix(int'(rx) + 1, int'(ry)));
    ld <= 8'(pix(int'(rx), int'(ry) + 1));
    rd <= 8'(pix(int'(rx) + 1, int'(ry) + 1));
  end

  // Scoreboard: record accepted requests, compare popped pixels in order, check head stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) check("hold_stable", int'({out_valid, out_pixel}), int'({1'b1, hold_pix}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", int'(out_pixel), -1);
        else check("out_pixel", int'(out_pixel), exp_q.pop_front());
      end
      hold_v   = out_valid && !out_ready;
      hold_pix = out_pixel;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_pixel(int'(in_x), int'(in_y)));
        n_acc++;
      end
    end
  end

  task automatic send_one(vec_t v);
    check("ready_before", int'(in_ready), 1);
    in_valid = 1'b1; in_x = v.x; in_y = v.y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rx", int'(rx), v.erx);
    check("ry", int'(ry), v.ery);
    repeat (3) @(posedge clk);
    #1 check("early_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    check("valid_t4", int'(out_valid), 1);
    check("pixel_t4", int'(out_pixel), v.epix);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, a1;
    tbl[0] = '{14'h020, 14'h030, 2, 3, 50};
    tbl[1] = '{14'h028, 14'h030, 2, 3, 50 + RB};
    tbl[2] = '{14'h078, 14'h000, 7, 0, 7};
    tbl[3] = '{14'h080, 14'h000, 8, 0, 0};
    tbl[4] = '{14'h000, 14'h078, 0, 7, 112};
    tbl[5] = '{14'h038, 14'h048, 3, 4, 75 + RB};
    tbl[6] = '{14'h074, 14'h07C, 7, 7, 119};
    tbl[7] = '{14'h010, 14'h3FF0, 1, 1023, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_x = 14'd0; in_y = 14'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pixel", int'(out_pixel), 0);
    check("rst_rx", int'(rx), 0);
    check("rst_ry", int'(ry), 0);
    rst = 1'b0;
    #1 check("ready_after_rst", int'(in_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) send_one(tbl[i]);

    // Backpressure: only fifo_depth requests admitted while the output is stalled.
    out_ready = 1'b0; n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_x = 14'($urandom_range(0, 16'h7F));
      in_y = 14'($urandom_range(0, 16'h7F));
      @(posedge clk); #1;
    end
    check("bp_accepted", n_acc, 8);
    check("bp_ready_low", int'(in_ready), 0);
    check("bp_full_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    a0 = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) a0 = n_acc;
      in_x = 14'($urandom_range(0, 16'h7F));
      in_y = 14'($urandom_range(0, 16'h7F));
      @(posedge clk); #1;
    end
    a1 = n_acc;
    check("stream_rate", a1 - a0, 10);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Reset in the middle of three in-flight requests.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = 14'h035; in_y = 14'h052;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_rx", int'(rx), 0);
    check("mid_rst_ry", int'(ry), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("mid_rst_ready", int'(in_ready), 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", int'(out_valid), 0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_x = 14'($urandom_range(0, 16'h8F));
      in_y = 14'($urandom_range(0, 16'h8F));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && !(exp_q.size() == 0 && !out_valid); i++) begin
      @(posedge clk); #1;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bilinear_sampler.md
BILINEAR_SAMPLER -- requirements
Module: bilinear_sampler

Interface
REQ-001 SHALL have parameter img_width, default 8: source image width in pixels (even, ≤1024).
REQ-002 SHALL have parameter img_height, default 8: source image height in pixels (even, ≤1024).
REQ-003 SHALL have parameter fill_value, default 8'd0: pixel emitted for out-of-bounds coordinates.
REQ-004 SHALL have parameter fifo_depth, default 8: output FIFO entries (power of 2, ≥8).
REQ-005 SHALL have a single clock and an asynchronous, active-high reset, with ports clk then rst.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 in_valid  input  1  source-coordinate request valid.
REQ-009 in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
REQ-010 in_x, in_y  input  14 each  unsigned 10.4 fixed-point source coordinate.
REQ-011 rx, ry  output  10 each  integer read coordinate to the four-bank image buffer.
REQ-012 lu, ru, ld, rd  input  8 each  neighbour pixels returned by the buffer, fixed 2 cycles after rx/ry change.
REQ-013 out_valid  output  1  interpolated pixel valid.
REQ-014 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-015 out_pixel  output  8  interpolated pixel.

Function
REQ-016 On acceptance at edge T: rx<=in_x[13:4], ry<=in_y[13:4] (registered); fx=in_x[3:0], fy=in_y[3:0] and oob flag carried in a matching 2-stage delay line.
REQ-017 Neighbours SHALL be sampled at edge T+2; horizontal blends h_u=lu*(16-fx)+ru*fx, h_d=ld*(16-fx)+rd*fx registered at T+3 (12 bits each).
REQ-018 Sum s=h_u*(16-fy)+h_d*fy (17 bits incl. rounding) SHALL be computed and pushed into the FIFO at edge T+4; result = s[15:8].
REQ-019 rx==img_width-1 SHALL force fx=0; ry==img_height-1 SHALL force fy=0 (no read beyond the edge is used).
REQ-020 rx>img_width-1 or ry>img_height-1 SHALL mark oob; the entry still traverses the pipeline and pushes fill_value; rx/ry driven as received.
REQ-021 in_ready SHALL be (fifo_count + inflight) < fifo_depth, inflight = accepted requests not yet pushed (0..4); no push is ever dropped.
REQ-022 With out_ready held high, throughput SHALL be one pixel per cycle; output order equals acceptance order.
REQ-023 Simultaneous push and pop, including when FIFO full, SHALL leave count unchanged and preserve order.
REQ-024 out_valid SHALL equal FIFO non-empty; out_pixel SHALL show the FIFO head and hold stable while out_valid && !out_ready.
REQ-025 With no acceptance, rx/ry SHALL hold their last values.

Reset
REQ-026 During rst: rx=0, ry=0, out_valid=0, out_pixel=0, FIFO empty, inflight=0, all delay-line valids cleared.
REQ-027 After rst deasserts, in_ready SHALL be 1 in the first cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight and queued entries; none emerge afterwards.

Configuration
REQ-029 Macro BILINEAR_SAMPLER_ROUND_EN defined: s includes +128 before the >>8 (round half up).
REQ-030 BILINEAR_SAMPLER_ROUND_EN undefined: no +128; result truncates; all timing identical.

Verification (img 8x8, buffer model pixel(x,y)=16*y+x, 2-cycle read latency)
REQ-031 in_x=0x020, in_y=0x030, out_ready=1 -> rx=2, ry=3 after edge T; out_valid at T+4 with out_pixel=50.
REQ-032 in_x=0x028, in_y=0x030 -> out_pixel=51 with ROUND_EN, 50 without.
REQ-033 in_x=0x078 (x=7.5), in_y=0x000 -> fx forced 0, out_pixel=7; in_x=0x080 -> oob, out_pixel=0.
REQ-034 in_valid=1 streaming 20 requests, out_ready=0 -> exactly 8 accepted then in_ready=0; out_ready=1 -> 8 pixels in order, then streaming resumes at 1/cycle.
REQ-035 Assert rst 2 cycles after 3 acceptances -> out_valid=0, rx=ry=0 immediately; none of the 3 results appear after release; in_ready=1.
